// File: rtl/tcp_tx_seg_gen.sv
// TCP transmit segment generator: reads flow TX state and buffer pointers,
// sizes one segment, enqueues its header descriptor and writes back snd_nxt.
module tcp_tx_seg_gen #(
    parameter int FLOWID_W         = 6,
    parameter int TX_PAYLOAD_PTR_W = 14,
    parameter int MAX_SEG_BYTES    = 1460
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sched_tx_val,
    input  logic [FLOWID_W-1:0]             sched_tx_flowid,
    input  logic                            sched_tx_force_ack,
    output logic                            sched_tx_rdy,
    output logic                            tx_state_rd_req_val,
    output logic [FLOWID_W-1:0]             tx_state_rd_req_addr,
    input  logic                            tx_state_rd_req_rdy,
    input  logic                            tx_state_rd_resp_val,
    input  logic [81+TX_PAYLOAD_PTR_W-1:0]  tx_state_rd_resp_data,
    output logic                            tx_state_rd_resp_rdy,
    output logic                            tx_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]             tx_ptr_rd_req_addr,
    input  logic                            tx_ptr_rd_req_rdy,
    input  logic                            tx_ptr_rd_resp_val,
    input  logic [2*TX_PAYLOAD_PTR_W+1:0]   tx_ptr_rd_resp_data,
    output logic                            tx_ptr_rd_resp_rdy,
    output logic                            tx_state_wr_req_val,
    output logic [FLOWID_W-1:0]             tx_state_wr_req_addr,
    output logic [33+TX_PAYLOAD_PTR_W-1:0]  tx_state_wr_req_data,
    input  logic                            tx_state_wr_req_rdy,
    output logic                            send_pkt_enq_val,
    output logic [FLOWID_W-1:0]             send_pkt_enq_flowid,
    output logic [31:0]                     send_pkt_enq_seq,
    output logic [31:0]                     send_pkt_enq_ack,
    output logic [7:0]                      send_pkt_enq_flags,
    output logic [TX_PAYLOAD_PTR_W-1:0]     send_pkt_enq_payload_addr,
    output logic [15:0]                     send_pkt_enq_payload_len,
    input  logic                            send_pkt_enq_rdy
);
    localparam int PW = TX_PAYLOAD_PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_RESP, CALC, EMIT, WR_BACK
    } state_t;

    state_t              state_q, state_d;
    logic [FLOWID_W-1:0] flowid_q;
    logic                force_q;
    logic                st_iss_q, ptr_iss_q, st_got_q, ptr_got_q;
    logic [31:0]         snd_nxt_q, rcv_nxt_q;
    logic [15:0]         snd_wnd_q, len_q, len_d;
    logic [PW-1:0]       next_ptr_q, head_q, tail_q;
    logic [PW-1:0]       unsent, inflight;
    logic [31:0]         usable, len32;

    logic sched_fire, st_req_fire, ptr_req_fire, st_resp_fire, ptr_resp_fire;

    assign sched_fire    = sched_tx_val & sched_tx_rdy;
    assign st_req_fire   = tx_state_rd_req_val & tx_state_rd_req_rdy;
    assign ptr_req_fire  = tx_ptr_rd_req_val & tx_ptr_rd_req_rdy;
    assign st_resp_fire  = tx_state_rd_resp_val & tx_state_rd_resp_rdy;
    assign ptr_resp_fire = tx_ptr_rd_resp_val & tx_ptr_rd_resp_rdy;

    assign sched_tx_rdy         = (state_q == IDLE);
    assign tx_state_rd_req_val  = (state_q == RD_REQ) && !st_iss_q;
    assign tx_ptr_rd_req_val    = (state_q == RD_REQ) && !ptr_iss_q;
    assign tx_state_rd_resp_rdy = (state_q == RD_RESP) && !st_got_q;
    assign tx_ptr_rd_resp_rdy   = (state_q == RD_RESP) && !ptr_got_q;
    assign tx_state_rd_req_addr = flowid_q;
    assign tx_ptr_rd_req_addr   = flowid_q;

    // Pointer differences wrap modulo 2^(W+1); the wrap bit separates full from empty
    assign unsent   = tail_q - next_ptr_q;
    assign inflight = next_ptr_q - head_q;

    always_comb begin
        usable = '0;
        if (32'(snd_wnd_q) > 32'(inflight))
            usable = 32'(snd_wnd_q) - 32'(inflight);
        len32 = 32'(unsent);
        if (usable < len32)
            len32 = usable;
        if (32'(MAX_SEG_BYTES) < len32)
            len32 = 32'(MAX_SEG_BYTES);
        len_d = 16'(len32);
    end

    assign send_pkt_enq_val          = (state_q == EMIT);
    assign send_pkt_enq_flowid       = flowid_q;
    assign send_pkt_enq_seq          = snd_nxt_q;
    assign send_pkt_enq_ack          = rcv_nxt_q;
    assign send_pkt_enq_flags        = (len_q != 16'd0) ? 8'h18 : 8'h10;
    assign send_pkt_enq_payload_addr = next_ptr_q[TX_PAYLOAD_PTR_W-1:0];
    assign send_pkt_enq_payload_len  = len_q;

    assign tx_state_wr_req_val  = (state_q == WR_BACK);
    assign tx_state_wr_req_addr = flowid_q;
    assign tx_state_wr_req_data = {snd_nxt_q + 32'(len_q),
                                   next_ptr_q + PW'(len_q)};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (sched_fire) state_d = RD_REQ;
            RD_REQ:
                if ((st_iss_q | st_req_fire) && (ptr_iss_q | ptr_req_fire))
                    state_d = RD_RESP;
            RD_RESP:
                if ((st_got_q | st_resp_fire) && (ptr_got_q | ptr_resp_fire))
                    state_d = CALC;
            CALC:
                state_d = (len_d != 16'd0 || force_q) ? EMIT : IDLE;
            EMIT:
                if (send_pkt_enq_rdy)
                    state_d = (len_q != 16'd0) ? WR_BACK : IDLE;
            WR_BACK:
                if (tx_state_wr_req_rdy) state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            flowid_q   <= '0;
            force_q    <= 1'b0;
            st_iss_q   <= 1'b0;
            ptr_iss_q  <= 1'b0;
            st_got_q   <= 1'b0;
            ptr_got_q  <= 1'b0;
            snd_nxt_q  <= '0;
            rcv_nxt_q  <= '0;
            snd_wnd_q  <= '0;
            next_ptr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q <= state_d;
            if (sched_fire) begin
                flowid_q  <= sched_tx_flowid;
                force_q   <= sched_tx_force_ack;
                st_iss_q  <= 1'b0;
                ptr_iss_q <= 1'b0;
                st_got_q  <= 1'b0;
                ptr_got_q <= 1'b0;
            end
            if (st_req_fire)  st_iss_q  <= 1'b1;
            if (ptr_req_fire) ptr_iss_q <= 1'b1;
            if (st_resp_fire) begin
                st_got_q <= 1'b1;
                {snd_nxt_q, rcv_nxt_q, snd_wnd_q, next_ptr_q} <= tx_state_rd_resp_data;
            end
            if (ptr_resp_fire) begin
                ptr_got_q <= 1'b1;
                {head_q, tail_q} <= tx_ptr_rd_resp_data;
            end
            if (state_q == CALC) len_q <= len_d;
        end
    end
endmodule

// File: tb/tb_tcp_tx_seg_gen.sv
// Scoreboard bench for tcp_tx_seg_gen: directed corner cases plus random
// flows checked against a plain-arithmetic segment sizing model.
module tb_tcp_tx_seg_gen;
    localparam int FW = 6;
    localparam int W  = 14;
    localparam int PW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              sched_tx_val, sched_tx_force_ack, sched_tx_rdy;
    logic [FW-1:0]     sched_tx_flowid;
    logic              tx_state_rd_req_val, tx_state_rd_req_rdy;
    logic [FW-1:0]     tx_state_rd_req_addr;
    logic              tx_state_rd_resp_val, tx_state_rd_resp_rdy;
    logic [81+W-1:0]   tx_state_rd_resp_data;
    logic              tx_ptr_rd_req_val, tx_ptr_rd_req_rdy;
    logic [FW-1:0]     tx_ptr_rd_req_addr;
    logic              tx_ptr_rd_resp_val, tx_ptr_rd_resp_rdy;
    logic [2*PW-1:0]   tx_ptr_rd_resp_data;
    logic              tx_state_wr_req_val, tx_state_wr_req_rdy;
    logic [FW-1:0]     tx_state_wr_req_addr;
    logic [33+W-1:0]   tx_state_wr_req_data;
    logic              send_pkt_enq_val, send_pkt_enq_rdy;
    logic [FW-1:0]     send_pkt_enq_flowid;
    logic [31:0]       send_pkt_enq_seq, send_pkt_enq_ack;
    logic [7:0]        send_pkt_enq_flags;
    logic [W-1:0]      send_pkt_enq_payload_addr;
    logic [15:0]       send_pkt_enq_payload_len;

    tcp_tx_seg_gen dut (
        .clk(clk), .rst(rst),
        .sched_tx_val(sched_tx_val), .sched_tx_flowid(sched_tx_flowid),
        .sched_tx_force_ack(sched_tx_force_ack), .sched_tx_rdy(sched_tx_rdy),
        .tx_state_rd_req_val(tx_state_rd_req_val),
        .tx_state_rd_req_addr(tx_state_rd_req_addr),
        .tx_state_rd_req_rdy(tx_state_rd_req_rdy),
        .tx_state_rd_resp_val(tx_state_rd_resp_val),
        .tx_state_rd_resp_data(tx_state_rd_resp_data),
        .tx_state_rd_resp_rdy(tx_state_rd_resp_rdy),
        .tx_ptr_rd_req_val(tx_ptr_rd_req_val),
        .tx_ptr_rd_req_addr(tx_ptr_rd_req_addr),
        .tx_ptr_rd_req_rdy(tx_ptr_rd_req_rdy),
        .tx_ptr_rd_resp_val(tx_ptr_rd_resp_val),
        .tx_ptr_rd_resp_data(tx_ptr_rd_resp_data),
        .tx_ptr_rd_resp_rdy(tx_ptr_rd_resp_rdy),
        .tx_state_wr_req_val(tx_state_wr_req_val),
        .tx_state_wr_req_addr(tx_state_wr_req_addr),
        .tx_state_wr_req_data(tx_state_wr_req_data),
        .tx_state_wr_req_rdy(tx_state_wr_req_rdy),
        .send_pkt_enq_val(send_pkt_enq_val),
        .send_pkt_enq_flowid(send_pkt_enq_flowid),
        .send_pkt_enq_seq(send_pkt_enq_seq),
        .send_pkt_enq_ack(send_pkt_enq_ack),
        .send_pkt_enq_flags(send_pkt_enq_flags),
        .send_pkt_enq_payload_addr(send_pkt_enq_payload_addr),
        .send_pkt_enq_payload_len(send_pkt_enq_payload_len),
        .send_pkt_enq_rdy(send_pkt_enq_rdy)
    );

    int errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
    int enq_cnt = 0, wr_cnt = 0;
    int st_dly = 0, ptr_dly = 0, rd_rand = 0, enq_mode = 0, wr_mode = 0;

    logic [31:0] m_snd[64], m_rcv[64];
    logic [15:0] m_wnd[64];
    logic [14:0] m_nptr[64], m_head[64], m_tail[64];

    logic [107:0] enq_q[$];
    logic [52:0]  wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Segment sizing from the flow record, modulo-2^15 pointer arithmetic
    function automatic void predict(input int f, input bit fa);
        int unsent, inflight, usable, len;
        logic [7:0]  fl;
        logic [31:0] s;
        unsent   = (int'(m_tail[f]) - int'(m_nptr[f]) + 32768) % 32768;
        inflight = (int'(m_nptr[f]) - int'(m_head[f]) + 32768) % 32768;
        usable   = (int'(m_wnd[f]) > inflight) ? int'(m_wnd[f]) - inflight : 0;
        len = unsent;
        if (usable < len) len = usable;
        if (1460 < len) len = 1460;
        if (len > 0 || fa) begin
            fl = (len > 0) ? 8'h18 : 8'h10;
            enq_q.push_back({6'(f), m_snd[f], m_rcv[f], fl, m_nptr[f][13:0], 16'(len)});
        end
        if (len > 0) begin
            s = m_snd[f] + 32'(len);
            wr_q.push_back({6'(f), s, 15'(int'(m_nptr[f]) + len)});
        end
    endfunction

    initial begin : st_mem
        logic rf, pf, pend;
        logic [FW-1:0] a;
        int cnt;
        tx_state_rd_req_rdy = 1'b0;
        tx_state_rd_resp_val = 1'b0;
        tx_state_rd_resp_data = '0;
        pend = 1'b0; cnt = 0; a = '0;
        forever begin
            @(negedge clk);
            rf = tx_state_rd_req_val & tx_state_rd_req_rdy;
            pf = tx_state_rd_resp_val & tx_state_rd_resp_rdy;
            if (rf) a = tx_state_rd_req_addr;
            @(posedge clk); #1;
            if (rst) begin
                tx_state_rd_resp_val = 1'b0;
                pend = 1'b0;
            end else begin
                if (pf) tx_state_rd_resp_val = 1'b0;
                if (rf) begin pend = 1'b1; cnt = st_dly; end
                if (pend) begin
                    if (cnt == 0) begin
                        tx_state_rd_resp_val = 1'b1;
                        tx_state_rd_resp_data = {m_snd[a], m_rcv[a], m_wnd[a], m_nptr[a]};
                        pend = 1'b0;
                    end else cnt--;
                end
            end
            tx_state_rd_req_rdy = (rd_rand != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : ptr_mem
        logic rf, pf, pend;
        logic [FW-1:0] a;
        int cnt;
        tx_ptr_rd_req_rdy = 1'b0;
        tx_ptr_rd_resp_val = 1'b0;
        tx_ptr_rd_resp_data = '0;
        pend = 1'b0; cnt = 0; a = '0;
        forever begin
            @(negedge clk);
            rf = tx_ptr_rd_req_val & tx_ptr_rd_req_rdy;
            pf = tx_ptr_rd_resp_val & tx_ptr_rd_resp_rdy;
            if (rf) a = tx_ptr_rd_req_addr;
            @(posedge clk); #1;
            if (rst) begin
                tx_ptr_rd_resp_val = 1'b0;
                pend = 1'b0;
            end else begin
                if (pf) tx_ptr_rd_resp_val = 1'b0;
                if (rf) begin pend = 1'b1; cnt = ptr_dly; end
                if (pend) begin
                    if (cnt == 0) begin
                        tx_ptr_rd_resp_val = 1'b1;
                        tx_ptr_rd_resp_data = {m_head[a], m_tail[a]};
                        pend = 1'b0;
                    end else cnt--;
                end
            end
            tx_ptr_rd_req_rdy = (rd_rand != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : rdy_drv
        send_pkt_enq_rdy = 1'b1;
        tx_state_wr_req_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (enq_mode == 2) send_pkt_enq_rdy = 1'b0;
            else if (enq_mode == 1) send_pkt_enq_rdy = ($urandom_range(0, 2) != 0);
            else send_pkt_enq_rdy = 1'b1;
            tx_state_wr_req_rdy = (wr_mode != 0) ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        logic [107:0] d, e, prev;
        logic [52:0]  w, we;
        logic stall;
        stall = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            if (rst) stall = 1'b0;
            else begin
                d = {send_pkt_enq_flowid, send_pkt_enq_seq, send_pkt_enq_ack,
                     send_pkt_enq_flags, send_pkt_enq_payload_addr,
                     send_pkt_enq_payload_len};
                if (send_pkt_enq_val)
                    chk("busy_sched_rdy", 128'(sched_tx_rdy), 128'd0);
                if (stall && send_pkt_enq_val)
                    chk("enq_stable", 128'(d), 128'(prev));
                if (send_pkt_enq_val && send_pkt_enq_rdy) begin
                    enq_cnt++;
                    if (enq_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL enq_unexpected: got %0h expected none", d);
                    end else begin
                        e = enq_q.pop_front();
                        chk("enq_desc", 128'(d), 128'(e));
                    end
                end
                stall = send_pkt_enq_val && !send_pkt_enq_rdy;
                prev = d;
                w = {tx_state_wr_req_addr, tx_state_wr_req_data};
                if (tx_state_wr_req_val && tx_state_wr_req_rdy) begin
                    wr_cnt++;
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected: got %0h expected none", w);
                    end else begin
                        we = wr_q.pop_front();
                        chk("wr_back", 128'(w), 128'(we));
                    end
                    m_snd[tx_state_wr_req_addr]  = tx_state_wr_req_data[46:15];
                    m_nptr[tx_state_wr_req_addr] = tx_state_wr_req_data[14:0];
                end
            end
        end
    end

    task automatic set_flow(input int f, input logic [14:0] h, input logic [14:0] t,
                            input logic [14:0] n, input logic [15:0] wnd,
                            input logic [31:0] s, input logic [31:0] r);
        m_head[f] = h; m_tail[f] = t; m_nptr[f] = n;
        m_wnd[f] = wnd; m_snd[f] = s; m_rcv[f] = r;
    endtask

    task automatic sched(input int f, input bit fa);
        int n;
        n = 0;
        @(posedge clk); #1;
        sched_tx_val = 1'b1;
        sched_tx_flowid = 6'(f);
        sched_tx_force_ack = fa;
        @(negedge clk);
        while (!sched_tx_rdy && n < 200) begin n++; @(negedge clk); end
        if (!sched_tx_rdy) begin
            checks++; errors++;
            $display("FAIL sched_timeout: got rdy=0 expected rdy=1");
        end else begin
            predict(f, fa);
            acc_cyc = cyc;
        end
        @(posedge clk); #1;
        sched_tx_val = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sched_tx_rdy && enq_q.size() == 0 && wr_q.size() == 0) && n < 500) begin
            n++; @(negedge clk);
        end
        chk("txn_done", 128'({enq_q.size() == 0, wr_q.size() == 0, sched_tx_rdy}),
            128'(3'b111));
    endtask

    task automatic wait_enq_val(output int n);
        n = 0;
        @(negedge clk);
        while (!send_pkt_enq_val && n < 50) begin n++; @(negedge clk); end
        if (!send_pkt_enq_val) begin
            checks++; errors++;
            $display("FAIL enq_timeout: got val=0 expected val=1");
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e0, w0, n, f, infl, uns, sel;
        logic [14:0] h;
        sched_tx_val = 1'b0; sched_tx_flowid = '0; sched_tx_force_ack = 1'b0;
        for (int i = 0; i < 64; i++) set_flow(i, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 128'({sched_tx_rdy, tx_state_rd_req_val, tx_ptr_rd_req_val,
                                tx_state_wr_req_val, send_pkt_enq_val}), 128'(5'b10000));

        set_flow(1, 15'd0, 15'd100, 15'd0, 16'd1000, 32'h1000, 32'h55);
        sched(1, 1'b0);
        wait_enq_val(n);
        chk("latency", 128'(cyc - acc_cyc), 128'd4);
        wait_done();
        chk("t1_snd", 128'(m_snd[1]), 128'h1064);
        chk("t1_nptr", 128'(m_nptr[1]), 128'd100);

        set_flow(2, 15'd0, 15'd5000, 15'd0, 16'hFFFF, 32'h2000, 32'h7);
        e0 = enq_cnt;
        sched(2, 1'b0); wait_done();
        sched(2, 1'b0); wait_done();
        chk("t2_enqs", 128'(enq_cnt - e0), 128'd2);
        chk("t2_snd", 128'(m_snd[2]), 128'(32'h2000 + 32'd2920));

        set_flow(3, 15'd0, 15'd1100, 15'd800, 16'd800, 32'h300, 32'h9);
        e0 = enq_cnt; w0 = wr_cnt;
        sched(3, 1'b0); wait_done();
        chk("t3_noemit", 128'({enq_cnt - e0, wr_cnt - w0}), 128'd0);
        sched(3, 1'b1); wait_done();
        chk("t3_force_enq", 128'(enq_cnt - e0), 128'd1);
        chk("t3_force_nowr", 128'(wr_cnt - w0), 128'd0);

        set_flow(4, 15'h3FF0, 15'h4010, 15'h3FF0, 16'd1000, 32'hFFFFFFF0, 32'h1);
        sched(4, 1'b0); wait_done();
        chk("t4_snd_wrap", 128'(m_snd[4]), 128'h10);
        chk("t4_nptr_wrap", 128'(m_nptr[4]), 128'h4010);

        set_flow(5, 15'd10, 15'd500, 15'd20, 16'd4000, 32'hABCD0000, 32'h1234);
        st_dly = 3; ptr_dly = 0; enq_mode = 2;
        e0 = enq_cnt;
        sched(5, 1'b0);
        wait_enq_val(n);
        repeat (10) @(negedge clk);
        enq_mode = 0;
        wait_done();
        chk("t5_one_enq", 128'(enq_cnt - e0), 128'd1);
        st_dly = 0;

        set_flow(6, 15'd0, 15'd64, 15'd0, 16'd1000, 32'h600, 32'h66);
        enq_mode = 2;
        w0 = wr_cnt;
        sched(6, 1'b0);
        wait_enq_val(n);
        #2 rst = 1'b1;
        #1;
        chk("rst_enq_async", 128'(send_pkt_enq_val), 128'd0);
        chk("rst_idle", 128'(sched_tx_rdy), 128'd1);
        enq_q.delete(); wr_q.delete();
        enq_mode = 0;
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_wr", 128'(wr_cnt - w0), 128'd0);
        chk("rst_snd_kept", 128'(m_snd[6]), 128'h600);

        rd_rand = 1; enq_mode = 1; wr_mode = 1;
        for (int i = 0; i < 150; i++) begin
            f = $urandom_range(0, 63);
            st_dly = $urandom_range(0, 3);
            ptr_dly = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                h = 15'($urandom);
                infl = $urandom_range(0, 3000);
                uns = $urandom_range(0, 4000);
                sel = $urandom_range(0, 5);
                if (sel == 0) uns = 0;
                if (sel == 1) begin infl = 0; uns = 16384; end
                m_head[f] = h;
                m_nptr[f] = h + 15'(infl);
                m_tail[f] = m_nptr[f] + 15'(uns);
                if (sel == 2) m_wnd[f] = 16'(infl);
                else if (sel == 3) m_wnd[f] = 16'(infl + $urandom_range(0, 200));
                else m_wnd[f] = 16'($urandom);
                m_snd[f] = $urandom;
                m_rcv[f] = $urandom;
            end
            sched(f, $urandom_range(0, 3) == 0);
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
